// File: rtl/csa_resolver_if.sv
// rtl/csa_resolver_if.sv - carry-save pair in / resolved result out handshake bundle
interface csa_resolver_if #(
    parameter int WIDTH = 35
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             ovf;

    // Producer/consumer side: drives the pair and the result acceptance
    modport master (
        output in_valid,
        output in_sum,
        output in_carry,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res,
        input  ovf
    );

    // Resolver side
    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_carry,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res,
        output ovf
    );
endinterface

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - chunk-serial carry-propagate resolver for carry-save pairs
module csa_resolver #(
    parameter int WIDTH = 35,
    parameter int CHUNK = 7
) (
    input logic           clk,
    input logic           rst,
    csa_resolver_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // A holds the sum vector, B the carry vector already shifted to its true weight;
    // hi is the carry bit that falls off the top when B is formed.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_hi;
    logic             r_cy;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_res_chunk;
    logic             w_cy_out;

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE passes out_ready through so a new
    // pair can be taken on the same edge the result is consumed
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = bus.in_valid ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Select the operand slices for the chunk currently being resolved
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    // Narrow ripple adder: one chunk plus the carry left over from the previous chunk
    assign {w_cy_out, w_res_chunk} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                                   + {{CHUNK{1'b0}}, r_cy};

    // Operand capture on accept, then one chunk written per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= 1'b0;
            r_cy  <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.in_sum;
            r_b   <= {bus.in_carry[WIDTH-2:0], 1'b0};
            r_hi  <= bus.in_carry[WIDTH-1];
            r_cy  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_res[k*CHUNK +: CHUNK] <= w_res_chunk;
                end
            end
            r_cy  <= w_cy_out;
            r_cnt <= r_cnt + CNT_W'(1);
            // The top chunk's carry-out and the dropped carry bit both mean the
            // exact value reached 2^WIDTH
            if (w_last) begin
                r_ovf <= w_cy_out | r_hi;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.res       = r_res;
    assign bus.ovf       = r_ovf;
endmodule
